// File: rtl/drm_bist.sv
`default_nettype none
// ============================================================================
// drm_bist : self-test controller for the drm_tag dual-port RAM.
//            Fills every word with a pattern, reads it back, and reports a verdict.
// Revision : 1.0
// ============================================================================
module drm_bist #(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic                                           mode,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           pass,
    output logic [ERR_CNT_WIDTH-1:0]                       err_cnt,
    output logic [ADDR_WIDTH-1:0]                          first_err_addr,
    output logic                                           mem_wr_en,
    output logic [ADDR_WIDTH-1:0]                          mem_wr_addr,
    output logic [DATA_WIDTH-1:0]                          mem_wr_data,
    output logic [((DATA_WIDTH/8 > 0) ? DATA_WIDTH/8 : 1)-1:0] mem_wr_byte_en,
    output logic [ADDR_WIDTH-1:0]                          mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]                          mem_rd_data
);

    localparam int BE_WIDTH  = (DATA_WIDTH/8 > 0) ? DATA_WIDTH/8 : 1;
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(1 << ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] DRAIN_CNT = CNT_WIDTH'(RD_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   state_q;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic                     mode_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     wr_en_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;
    logic [ADDR_WIDTH-1:0]    rd_addr_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_d;
    logic [ADDR_WIDTH-1:0]    first_err_q;
    logic [ADDR_WIDTH-1:0]    first_err_d;

    logic                     pipe_vld_q  [RD_LATENCY];
    logic [DATA_WIDTH-1:0]    pipe_exp_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]    pipe_addr_q [RD_LATENCY];
    logic                     w_mismatch;

    // Mode 0: all-ones minus address; mode 1: 0101.. on even, 1010.. on odd addresses.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic m, input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] p;
        p = ~DATA_WIDTH'(a);
        if (m) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                p[i] = a[0] ^ ~i[0];
            end
        end
        return p;
    endfunction

    // Expected word travels alongside the RAM read latency so it meets mem_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_exp_q[i]  <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= (state_q == S_READ);
            pipe_exp_q[0]  <= pattern(mode_q, rd_addr_q);
            pipe_addr_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    assign w_mismatch = pipe_vld_q[RD_LATENCY-1] && (mem_rd_data != pipe_exp_q[RD_LATENCY-1]);

    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (w_mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
            if (err_cnt_q == '0) begin
                first_err_d = pipe_addr_q[RD_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_WRITE;
                        mode_q      <= mode;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        wr_en_q     <= 1'b1;
                        wr_addr_q   <= '0;
                        wr_data_q   <= pattern(mode, {ADDR_WIDTH{1'b0}});
                        cnt_q       <= CNT_ONE;
                    end
                end
                S_WRITE: begin
                    // cnt_q holds the next address; reaching N means address N-1 is on the bus.
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= S_GAP;
                        wr_en_q   <= 1'b0;
                        wr_addr_q <= '0;
                        wr_data_q <= '0;
                        cnt_q     <= '0;
                    end else begin
                        wr_addr_q <= cnt_q[ADDR_WIDTH-1:0];
                        wr_data_q <= pattern(mode_q, cnt_q[ADDR_WIDTH-1:0]);
                        cnt_q     <= cnt_q + CNT_ONE;
                    end
                end
                S_GAP: begin
                    state_q   <= S_READ;
                    rd_addr_q <= '0;
                    cnt_q     <= CNT_ONE;
                end
                S_READ: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= S_DRAIN;
                        rd_addr_q <= '0;
                        cnt_q     <= CNT_ONE;
                    end else begin
                        rd_addr_q <= cnt_q[ADDR_WIDTH-1:0];
                        cnt_q     <= cnt_q + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_CNT) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (err_cnt_q == '0);
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign mem_wr_en      = wr_en_q;
    assign mem_wr_addr    = wr_addr_q;
    assign mem_wr_data    = wr_data_q;
    assign mem_wr_byte_en = {BE_WIDTH{1'b1}};
    assign mem_rd_addr    = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_drm_bist.sv
`default_nettype none
// tb_drm_bist: two BIST instances (read latency 1 and 2) with behavioural RAMs,
// checked every cycle against a run-relative reference model.
module tb_drm_bist;

    localparam int N  = 64;
    localparam int AW = 6;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_s   [2];
    logic       mode_s    [2];
    int         fault_sel [2];

    logic       busy_o    [2];
    logic       done_o    [2];
    logic       pass_o    [2];
    logic [2:0] err_o     [2];
    logic [5:0] ferr_o    [2];
    logic       wr_en_o   [2];
    logic [5:0] wr_addr_o [2];
    logic [7:0] wr_data_o [2];
    logic [0:0] be_o      [2];
    logic [5:0] rd_addr_o [2];
    logic [7:0] rd_data_i [2];

    int total = 0;
    int bad   = 0;

    drm_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mode(mode_s[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_cnt(err_o[0]),
        .first_err_addr(ferr_o[0]), .mem_wr_en(wr_en_o[0]), .mem_wr_addr(wr_addr_o[0]),
        .mem_wr_data(wr_data_o[0]), .mem_wr_byte_en(be_o[0]), .mem_rd_addr(rd_addr_o[0]),
        .mem_rd_data(rd_data_i[0])
    );

    drm_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mode(mode_s[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_cnt(err_o[1]),
        .first_err_addr(ferr_o[1]), .mem_wr_en(wr_en_o[1]), .mem_wr_addr(wr_addr_o[1]),
        .mem_wr_data(wr_data_o[1]), .mem_wr_byte_en(be_o[1]), .mem_rd_addr(rd_addr_o[1]),
        .mem_rd_data(rd_data_i[1])
    );

    function automatic logic [7:0] pat(input bit m, input int a);
        if (m) return (a % 2 == 0) ? 8'h55 : 8'hAA;
        return 8'(255 - a);
    endfunction

    // Fault 1: bit 0 stuck at 0 at address 4. Fault 2: read port returns zero.
    function automatic logic [7:0] readback(input int f, input bit m, input int a);
        if (f == 2) return 8'h00;
        if (f == 1 && a == 4) return pat(m, a) & 8'hFE;
        return pat(m, a);
    endfunction

    logic [7:0] mem0 [N];
    logic [7:0] mem1 [N];
    logic [7:0] rd1_stage;

    always @(posedge clk) begin
        if (wr_en_o[0])
            mem0[wr_addr_o[0]] <= (fault_sel[0] == 1 && wr_addr_o[0] == 6'd4) ? (wr_data_o[0] & 8'hFE) : wr_data_o[0];
        if (wr_en_o[1])
            mem1[wr_addr_o[1]] <= (fault_sel[1] == 1 && wr_addr_o[1] == 6'd4) ? (wr_data_o[1] & 8'hFE) : wr_data_o[1];
        rd_data_i[0] <= (fault_sel[0] == 2) ? 8'h00 : mem0[rd_addr_o[0]];
        rd1_stage    <= (fault_sel[1] == 2) ? 8'h00 : mem1[rd_addr_o[1]];
        rd_data_i[1] <= rd1_stage;
    end

    // Reference model: t = cycles since the accepted start (t=1 is the first WRITE cycle).
    bit m_act   [2];
    int m_t     [2];
    bit m_mode  [2];
    int m_fault [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d] <= 1'b0;
                m_t[d]   <= 0;
            end else if (start_s[d] && (!m_act[d] || m_t[d] >= 2*N + 3 + d)) begin
                m_act[d]   <= 1'b1;
                m_t[d]     <= 1;
                m_mode[d]  <= mode_s[d];
                m_fault[d] <= fault_sel[d];
            end else if (m_act[d] && m_t[d] < 10000) begin
                m_t[d] <= m_t[d] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int d, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, d, got, want, $time);
        end
    endtask

    task automatic check_dut(input int d);
        int  t, lat, errs, first;
        bit  act, e_busy, e_wr, e_done;
        int  e_waddr, e_wdata, e_raddr;
        act = m_act[d];
        t   = m_t[d];
        lat = d + 1;
        e_busy  = act && t >= 1 && t <= 2*N + 1 + lat;
        e_wr    = act && t >= 1 && t <= N;
        e_waddr = e_wr ? t - 1 : 0;
        e_wdata = e_wr ? int'(pat(m_mode[d], t - 1)) : 0;
        e_raddr = (act && t >= N + 2 && t <= 2*N + 1) ? t - N - 2 : 0;
        e_done  = act && t >= 2*N + 2 + lat;
        errs  = 0;
        first = 0;
        if (act) begin
            for (int k = 0; k < N; k++) begin
                if (N + 3 + k + lat <= t && readback(m_fault[d], m_mode[d], k) != pat(m_mode[d], k)) begin
                    if (errs == 0) first = k;
                    errs++;
                end
            end
        end
        if (errs > 7) errs = 7;
        chk("busy",    d, int'(busy_o[d]),    int'(e_busy));
        chk("done",    d, int'(done_o[d]),    int'(e_done));
        chk("pass",    d, int'(pass_o[d]),    int'(e_done && errs == 0));
        chk("err_cnt", d, int'(err_o[d]),     errs);
        chk("first",   d, int'(ferr_o[d]),    first);
        chk("wr_en",   d, int'(wr_en_o[d]),   int'(e_wr));
        chk("wr_addr", d, int'(wr_addr_o[d]), e_waddr);
        chk("wr_data", d, int'(wr_data_o[d]), e_wdata);
        chk("rd_addr", d, int'(rd_addr_o[d]), e_raddr);
        chk("byte_en", d, int'(be_o[d]),      1);
    endtask

    always @(negedge clk) begin
        check_dut(0);
        check_dut(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Returns in the first WRITE cycle of the new run.
    task automatic launch(input int d, input bit m, input int f);
        fault_sel[d] = f;
        mode_s[d]    = m;
        start_s[d]   = 1'b1;
        tick();
        start_s[d]   = 1'b0;
        mode_s[d]    = ~m;
    endtask

    initial begin
        rst_n        = 1'b0;
        start_s[0]   = 1'b0;
        start_s[1]   = 1'b0;
        mode_s[0]    = 1'b0;
        mode_s[1]    = 1'b0;
        fault_sel[0] = 0;
        fault_sel[1] = 0;
        repeat (3) tick();
        chk("rst_done",    0, int'(done_o[0]),  0);
        chk("rst_busy",    1, int'(busy_o[1]),  0);
        chk("rst_byte_en", 0, int'(be_o[0]),    1);
        chk("rst_wr_en",   0, int'(wr_en_o[0]), 0);
        rst_n = 1'b1;
        tick();

        // Clean run, latency 1, mode 0
        launch(0, 1'b0, 0);
        chk("lit_wdata_a0",  0, int'(wr_data_o[0]), 'hFF);
        repeat (63) tick();
        chk("lit_wdata_a63", 0, int'(wr_data_o[0]), 'hC0);
        chk("lit_waddr_a63", 0, int'(wr_addr_o[0]), 63);
        repeat (66) tick();
        chk("lit_done_130",  0, int'(done_o[0]), 0);
        tick();
        chk("lit_done_131",  0, int'(done_o[0]), 1);
        chk("lit_pass_131",  0, int'(pass_o[0]), 1);
        chk("lit_err_clean", 0, int'(err_o[0]),  0);

        // Single stuck bit at address 4
        launch(0, 1'b0, 1);
        repeat (130) tick();
        chk("lit_err_single",   0, int'(err_o[0]),  1);
        chk("lit_first_single", 0, int'(ferr_o[0]), 4);
        chk("lit_pass_single",  0, int'(pass_o[0]), 0);

        // Everything wrong: counter saturates
        launch(0, 1'b0, 2);
        repeat (130) tick();
        chk("lit_err_sat",   0, int'(err_o[0]),  7);
        chk("lit_first_sat", 0, int'(ferr_o[0]), 0);
        chk("lit_pass_sat",  0, int'(pass_o[0]), 0);

        // Checkerboard, latency 2, with an ignored start during READ
        launch(1, 1'b1, 0);
        chk("lit_cb_a0", 1, int'(wr_data_o[1]), 'h55);
        tick();
        chk("lit_cb_a1", 1, int'(wr_data_o[1]), 'hAA);
        repeat (74) tick();
        start_s[1] = 1'b1;
        mode_s[1]  = 1'b0;
        tick();
        start_s[1] = 1'b0;
        repeat (54) tick();
        chk("lit_cb_done_131", 1, int'(done_o[1]), 0);
        tick();
        chk("lit_cb_done_132", 1, int'(done_o[1]), 1);
        chk("lit_cb_pass",     1, int'(pass_o[1]), 1);

        // Reset in the middle of WRITE
        launch(0, 1'b0, 0);
        repeat (19) tick();
        chk("lit_wr_en_20", 0, int'(wr_en_o[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("lit_async_wr_en", 0, int'(wr_en_o[0]), 0);
        chk("lit_async_busy",  0, int'(busy_o[0]),  0);
        chk("lit_async_done0", 0, int'(done_o[0]),  0);
        chk("lit_async_done1", 1, int'(done_o[1]),  0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        launch(0, 1'b0, 0);
        repeat (129) tick();
        chk("lit_rerun_done_130", 0, int'(done_o[0]), 0);
        tick();
        chk("lit_rerun_done_131", 0, int'(done_o[0]), 1);
        chk("lit_rerun_pass",     0, int'(pass_o[0]), 1);

        // Randomised runs, stray starts and occasional resets
        for (int c = 0; c < 4000; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!m_act[d] || m_t[d] >= 2*N + 3 + d) begin
                    if ($urandom_range(0, 3) == 0) begin
                        fault_sel[d] = int'($urandom_range(0, 2));
                        mode_s[d]    = 1'($urandom_range(0, 1));
                        start_s[d]   = 1'b1;
                    end else begin
                        start_s[d] = 1'b0;
                    end
                end else begin
                    start_s[d] = ($urandom_range(0, 15) == 0);
                    mode_s[d]  = 1'($urandom_range(0, 1));
                end
            end
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        rst_n      = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/drm_bist.md
# drm_bist

Synthesizable built-in self-test controller for the simple dual-port tag RAM (`drm_tag`, same-clock configuration). It drives the RAM's write port to fill every address with a known pattern, then drives the read port to sweep every address back, compares each returned word and reports a pass/fail verdict. Its counterpart is the RAM: `drm_bist` initiates on both ports and the RAM responds. It sits beside the tag RAM and is muxed onto the RAM ports during power-on or debug self-test.

## Interface
- `ADDR_WIDTH`, 6, RAM address width; N = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 8, RAM data width.
- `RD_LATENCY`, 1, RAM read latency in cycles; legal values are 1 (no output register) or 2 (output register).
- `ERR_CNT_WIDTH`, 3, width of the saturating error counter.

- `clk` in 1: single clock for the RAM write and read ports.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE or DONE.
- `mode` in 1: pattern select, sampled with `start`. 0 = descending count, 1 = checkerboard.
- `busy` out 1: high from WRITE through DRAIN.
- `done` out 1: high in DONE; level, held until the next accepted `start`.
- `pass` out 1: `done & (err_cnt == 0)`.
- `err_cnt` out ERR_CNT_WIDTH: mismatch count; saturates at all-ones.
- `first_err_addr` out ADDR_WIDTH: address of the first mismatch; 0 if there was none.
- `mem_wr_en` out 1: RAM write enable.
- `mem_wr_addr` out ADDR_WIDTH: RAM write address.
- `mem_wr_data` out DATA_WIDTH: RAM write data.
- `mem_wr_byte_en` out DATA_WIDTH/8 (minimum 1): tied all-ones.
- `mem_rd_addr` out ADDR_WIDTH: RAM read address.
- `mem_rd_data` in DATA_WIDTH: RAM read data.

## Operation
- **Reset values:** FSM = IDLE. All outputs are 0, except `mem_wr_byte_en`, which is all-ones.
- **Patterns**, for address `a`:
  - Mode 0: `(2^DATA_WIDTH - 1 - a) mod 2^DATA_WIDTH`, giving 0xFF, 0xFE, … for DATA_WIDTH = 8.
  - Mode 1: bit `i` = `a[0] ^ ~i[0]`, giving 0x55 at even addresses and 0xAA at odd addresses.
- **FSM states:** IDLE → WRITE → GAP → READ → DRAIN → DONE.
  - IDLE / DONE: when `start`=1, latch `mode`, clear `err_cnt` and `first_err_addr`, drop `done`, and go to WRITE.
  - WRITE: `mem_wr_en`=1; address counts 0 to N-1; leave after address N-1.
  - GAP: exactly 1 cycle with no RAM activity.
  - READ: `mem_rd_addr` counts 0 to N-1, one address per cycle.
  - DRAIN: exactly RD_LATENCY cycles.
  - DONE: `done`=1.
- **Compare:**
  - The expected word and a valid flag are delayed through an RD_LATENCY-deep pipeline aligned with `mem_rd_data`.
  - On a valid mismatch, `err_cnt` increments (saturating).
  - `first_err_addr` is captured on the first mismatch only.
- **Idle output values:** outside WRITE, `mem_wr_en`, `mem_wr_addr` and `mem_wr_data` are 0. Outside READ, `mem_rd_addr` is 0.
- **`start` while busy:** ignored; no restart and no state change.
- **Address counters:** ADDR_WIDTH+1 bits wide, so the terminal condition is not lost to wrap-around.
- **Reset mid-test:** `rst_n` low forces all outputs and the FSM to reset values immediately (asynchronously), including `mem_wr_en`=0. RAM contents are undefined afterward; a new `start` runs the full test.

## Timing
- Cycle 0: `start` is sampled.
- Cycles 1..N: WRITE. In cycle k+1, `mem_wr_addr`=k and `mem_wr_data`=pattern(k).
- Cycle N+1: GAP.
- Cycles N+2..2N+1: READ. In cycle N+2+k, `mem_rd_addr`=k.
- `mem_rd_data` for address k is valid in cycle N+2+k+RD_LATENCY. It is compared in that cycle, and the counters update at that cycle's closing edge.
- Cycles 2N+2..2N+1+RD_LATENCY: DRAIN.
- Cycle 2N+2+RD_LATENCY: DONE entered. `done` and `pass` are valid with final counts.
- `busy` is high in cycles 1..2N+1+RD_LATENCY.
- Back-to-back run: `start` in the first DONE cycle begins WRITE on the next cycle.

## Test plan
- **Clean run, RD_LATENCY=1:** N=64, behavioural RAM, mode 0, `start` at cycle 0 → `done` rises at cycle 131; `pass`=1; `err_cnt`=0; `first_err_addr`=0; write data at address 0 is 0xFF and at address 63 is 0xC0.
- **Single fault:** RAM model with bit 0 stuck at 0 at address 4, mode 0 → written 0xFB, read 0xFA; `err_cnt`=1; `first_err_addr`=4; `pass`=0.
- **Saturation:** RAM model returns 0x00 everywhere, mode 0 → 64 mismatches; `err_cnt`=7 (saturated); `first_err_addr`=0; `pass`=0.
- **Checkerboard, RD_LATENCY=2:** RAM with output register, mode 1 → writes alternate 0x55/0xAA; `done` at cycle 132; `pass`=1. Then assert `start` again during READ → ignored; the run still completes at cycle 132.
- **Reset mid-WRITE:** `rst_n` low at cycle 20 → `mem_wr_en`, `busy` and `done` go to 0 immediately. After release, `start` → full run; `pass`=1 at the expected cycle relative to the new start.
